// File: rtl/uart_frame_pkg.sv
// Shared definitions for the 12-bit UART frame {START, DATA[7:0], PARITY, STOP[1:0]}.
// Used by both the frame packer and the frame receiver.
package uart_frame_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STOP_W  = 2;
  localparam int unsigned FRAME_W = 12;

  localparam int unsigned START_POS  = 11;
  localparam int unsigned DATA_MSB   = 10;
  localparam int unsigned DATA_LSB   = 3;
  localparam int unsigned PARITY_POS = 2;
  localparam int unsigned STOP_MSB   = 1;
  localparam int unsigned STOP_LSB   = 0;

  localparam logic              START_VAL = 1'b1;
  localparam logic [STOP_W-1:0] STOP_VAL  = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StStartChk,
    StShift,
    StDone
  } rx_state_e;

  // Even parity: the parity bit equals the XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that parks at zero; tc flags the terminal count.
module uart_bit_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             tc
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/uart_frame_rx.sv
// 12-bit UART frame receiver: synchronises the line, samples each bit at its centre,
// rebuilds the frame and holds it with error flags in a one-entry valid/ready register.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rxd,
  input  logic               ready,
  output logic               valid,
  output logic [FRAME_W-1:0] frame,
  output logic [DATA_W-1:0]  data,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overrun
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LastIdx  = 4'(FRAME_W - 2);

  logic [1:0]         sync_q;
  logic               rxs;
  logic               rxs_prev_q;
  logic               start_edge;
  logic               capture;
  rx_state_e          state_q;
  logic [3:0]         bit_idx_q;
  logic [FRAME_W-1:0] shift_q;
  logic               tmr_load;
  logic [CntW-1:0]    tmr_val;
  logic               tmr_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      rxs_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rxd};
      rxs_prev_q <= sync_q[1];
    end
  end

  assign rxs        = sync_q[1];
  assign start_edge = rxs & ~rxs_prev_q;
  // A finished frame may enter the output register if it is empty or being drained.
  assign capture    = ~valid | ready;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = BitLoad;
    case (state_q)
      StIdle: begin
        tmr_load = start_edge;
        tmr_val  = HalfLoad;
      end
      StStartChk: tmr_load = tmr_tc & rxs;
      StShift:    tmr_load = tmr_tc;
      default:    tmr_load = 1'b0;
    endcase
  end

  uart_bit_timer #(
    .Width(CntW)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tc      (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      valid      <= 1'b0;
      frame      <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // A same-cycle capture in StDone overrides this drain.
      if (valid && ready) begin
        valid <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q <= StStartChk;
          end
        end
        StStartChk: begin
          if (tmr_tc) begin
            if (rxs) begin
              shift_q[START_POS] <= START_VAL;
              bit_idx_q          <= LastIdx;
              state_q            <= StShift;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StShift: begin
          if (tmr_tc) begin
            shift_q[bit_idx_q] <= rxs;
            if (bit_idx_q == '0) begin
              state_q <= StDone;
            end else begin
              bit_idx_q <= bit_idx_q - 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          if (capture) begin
            valid      <= 1'b1;
            frame      <= shift_q;
            parity_err <= shift_q[PARITY_POS] != even_parity(shift_q[DATA_MSB:DATA_LSB]);
            frame_err  <= shift_q[STOP_MSB:STOP_LSB] != STOP_VAL;
          end else begin
            overrun <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data = frame[DATA_MSB:DATA_LSB];

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: table-driven frames, hand-written corner
// sequences (glitch, overrun, accept-with-capture, mid-frame reset) and random frames.
module tb_uart_frame_rx;

  localparam int C         = 16;
  localparam int LAT       = C / 2 + 11 * C + 4;  // from RXD change to VALID seen
  localparam int FRAME_CYC = 12 * C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b0;
  logic        ready = 1'b0;
  logic        valid;
  logic [11:0] frame;
  logic [7:0]  data;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = -1;
  int   ovr_cycles = 0;
  logic valid_d = 1'b0;

  typedef struct packed {
    logic [11:0] bits;
    logic [11:0] exp_frame;
    logic [7:0]  exp_data;
    logic        exp_perr;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs [4];

  uart_frame_rx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .ready     (ready),
    .valid     (valid),
    .frame     (frame),
    .data      (data),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    valid_d <= valid;
    if (valid && !valid_d) rise_cyc <= cyc;
    if (overrun) ovr_cycles <= ovr_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive the first ncyc cycles of a frame, MSB first; optionally pulse READY at cycle ready_at.
  task automatic drive_bits(input logic [11:0] f, input int ncyc, input int ready_at);
    logic [11:0] sh;
    sh = f;
    start_cyc = cyc;
    for (int k = 0; k < ncyc; k++) begin
      rxd = sh[11];
      if (k == ready_at) ready = 1'b1;
      else if (k == ready_at + 1) ready = 1'b0;
      @(negedge clk);
      if ((k + 1) % C == 0) sh = sh << 1;
    end
    rxd = 1'b0;
  endtask

  task automatic check_held(input string name, input logic [11:0] ef, input logic [7:0] ed,
                            input logic ep, input logic efe);
    check({name, "_valid"}, 32'(valid), 32'd1);
    check({name, "_frame"}, 32'(frame), 32'(ef));
    check({name, "_data"}, 32'(data), 32'(ed));
    check({name, "_perr"}, 32'(parity_err), 32'(ep));
    check({name, "_ferr"}, 32'(frame_err), 32'(efe));
  endtask

  task automatic consume(input string name);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check({name, "_drain"}, 32'(valid), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_frame(input string name, input logic [11:0] bits, input logic [11:0] ef,
                           input logic [7:0] ed, input logic ep, input logic efe);
    drive_bits(bits, FRAME_CYC, -1);
    repeat (8) @(negedge clk);
    check({name, "_latency"}, 32'(rise_cyc - start_cyc), 32'(LAT));
    check_held(name, ef, ed, ep, efe);
    consume(name);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, 32'(valid), 32'd0);
    check({name, "_frame"}, 32'(frame), 32'h000);
    check({name, "_data"}, 32'(data), 32'h00);
    check({name, "_perr"}, 32'(parity_err), 32'd0);
    check({name, "_ferr"}, 32'(frame_err), 32'd0);
    check({name, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int          o0;
    int          rsave;
    logic [7:0]  rd;
    logic        rp;
    logic [1:0]  rs;
    logic [11:0] rbits;

    vecs[0] = '{bits: 12'hD28, exp_frame: 12'hD28, exp_data: 8'hA5, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{bits: 12'h9E4, exp_frame: 12'h9E4, exp_data: 8'h3C, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{bits: 12'h80D, exp_frame: 12'h80D, exp_data: 8'h01, exp_perr: 1'b0, exp_ferr: 1'b1};
    vecs[3] = '{bits: 12'h807, exp_frame: 12'h807, exp_data: 8'h00, exp_perr: 1'b1, exp_ferr: 1'b1};

    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("after_reset");

    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].exp_frame, vecs[i].exp_data,
                vecs[i].exp_perr, vecs[i].exp_ferr);
    end

    // Short START glitch must be ignored; the next good frame still arrives.
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rxd = 1'b0;
    repeat (LAT + 20) @(negedge clk);
    check("glitch_no_valid", 32'(valid), 32'd0);
    run_frame("after_glitch", 12'hAD0, 12'hAD0, 8'h5A, 1'b0, 1'b0);

    // Overrun: second frame dropped while the first is held.
    o0 = ovr_cycles;
    drive_bits(12'hD28, FRAME_CYC, -1);
    repeat (8) @(negedge clk);
    check_held("ovr_first", 12'hD28, 8'hA5, 1'b0, 1'b0);
    drive_bits(12'h9E4, FRAME_CYC, -1);
    repeat (8) @(negedge clk);
    check("ovr_pulse_cycles", 32'(ovr_cycles - o0), 32'd1);
    check_held("ovr_held", 12'hD28, 8'hA5, 1'b0, 1'b0);

    // READY coincides with DONE of the third frame: replacement, VALID never drops.
    rsave = rise_cyc;
    drive_bits(12'hAD0, FRAME_CYC, LAT - 1);
    repeat (8) @(negedge clk);
    check("replace_no_ovr", 32'(ovr_cycles - o0), 32'd1);
    check("replace_valid_kept", 32'(rise_cyc), 32'(rsave));
    check_held("replace", 12'hAD0, 8'h5A, 1'b0, 1'b0);
    consume("replace");

    // Hold a flagged frame, then reset during DATA bit 4 of the next one.
    drive_bits(12'h807, FRAME_CYC, -1);
    repeat (8) @(negedge clk);
    check_held("pre_reset", 12'h807, 8'h00, 1'b1, 1'b1);
    drive_bits(12'hFF8, 70, -1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", 32'(valid), 32'd0);
    run_frame("post_reset", 12'hFF8, 12'hFF8, 8'hFF, 1'b0, 1'b0);

    // Random frames against the field-level model.
    for (int i = 0; i < 10; i++) begin
      rd    = 8'($urandom_range(0, 255));
      rp    = 1'($urandom_range(0, 1));
      rs    = 2'($urandom_range(0, 3));
      rbits = {1'b1, rd, rp, rs};
      run_frame($sformatf("rand%0d", i), rbits, rbits, rd, rp != (^rd), rs != 2'b00);
      repeat ($urandom_range(2, 20)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
